cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache-line width in bits.
REQ-003 SHALL have parameter OFFSET_W, default 4, line-offset bits forced to zero on pmem_address.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port icache_pmem_read  input  1  instruction-cache line-fill request.
REQ-007 SHALL have port icache_pmem_address  input  ADDR_W  instruction-cache line address.
REQ-008 SHALL have port icache_pmem_rdata  output  LINE_W  line returned to instruction cache.
REQ-009 SHALL have port icache_pmem_resp  output  1  instruction-cache transaction done.
REQ-010 SHALL have port dcache_pmem_read  input  1  data-cache line-fill request.
REQ-011 SHALL have port dcache_pmem_write  input  1  data-cache writeback request.
REQ-012 SHALL have port dcache_pmem_address  input  ADDR_W  data-cache line address.
REQ-013 SHALL have port dcache_pmem_wdata  input  LINE_W  writeback line.
REQ-014 SHALL have port dcache_pmem_rdata  output  LINE_W  line returned to data cache.
REQ-015 SHALL have port dcache_pmem_resp  output  1  data-cache transaction done.
REQ-016 SHALL have port pmem_read  output  1  physical-memory read strobe.
REQ-017 SHALL have port pmem_write  output  1  physical-memory write strobe.
REQ-018 SHALL have port pmem_address  output  ADDR_W  physical-memory line address.
REQ-019 SHALL have port pmem_wdata  output  LINE_W  physical-memory write line.
REQ-020 SHALL have port pmem_rdata  input  LINE_W  physical-memory read line.
REQ-021 SHALL have port pmem_resp  input  1  physical-memory transaction done.
REQ-022 SHALL have port arb_busy  output  1  high whenever state is not IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-024 SHALL keep register last_grant (I or D) updated on every grant.
REQ-025 IDLE, only icache request: next state SERVE_I; only dcache request (read or write): next state SERVE_D; none: stay IDLE.
REQ-026 IDLE, both requesting: grant the requester not in last_grant (round-robin); this gives each requester at most one transaction of wait.
REQ-027 On the grant edge SHALL latch the granted requester's address, wdata and operation into a transaction register; later requester input changes SHALL be ignored until completion.
REQ-028 dcache_pmem_read and dcache_pmem_write both high: treat as write; latch op=write.
REQ-029 In SERVE_x SHALL drive pmem_read or pmem_write (from latched op) continuously until pmem_resp; never both; both low in IDLE.
REQ-030 pmem_address SHALL equal latched address with bits [OFFSET_W-1:0] zeroed; pmem_wdata SHALL equal latched wdata (zero for icache).
REQ-031 In SERVE_x with pmem_resp high: assert x_pmem_resp for exactly that cycle, x_pmem_rdata = pmem_rdata combinationally; next state IDLE.
REQ-032 Non-granted requester's resp SHALL stay 0; its rdata SHALL be 0.
REQ-033 Minimum latency: request at cycle N, pmem strobe at N+1, resp same cycle as pmem_resp; one IDLE cycle between back-to-back transactions.
REQ-034 pmem_resp in IDLE SHALL be ignored (no resp forwarded, no state change).
REQ-035 Requesters deassert in the cycle after their resp; a request still high in IDLE SHALL be treated as new.

Reset
REQ-036 rst high at a rising edge: state=IDLE, last_grant=I, transaction register=0, regardless of state, including mid-transaction.
REQ-037 During and one cycle after rst: pmem_read, pmem_write, both resp, arb_busy = 0; rdata outputs = 0; pmem_address, pmem_wdata = 0.
REQ-038 An in-flight transaction aborted by rst SHALL NOT be resumed; a late pmem_resp after reset SHALL be ignored per REQ-034.

Verification
REQ-039 icache read 0x1234 alone, pmem_resp after 3 cycles with 0xA5..A5 -> pmem_address=0x1230, pmem_read 3 cycles, icache_pmem_resp 1 cycle with 0xA5..A5.
REQ-040 Both request from reset -> dcache served first (last_grant=I), then icache after one IDLE cycle; repeat tie -> icache first.
REQ-041 dcache write 0x4008 wdata 0xDEAD..BEEF; address input changed mid-transaction -> pmem_address stays 0x4000, pmem_write held, wdata unchanged.
REQ-042 dcache read+write together -> only pmem_write asserted.
REQ-043 rst during SERVE_D, then pmem_resp -> no dcache_pmem_resp, state IDLE, arb_busy 0.
REQ-044 Spurious pmem_resp in IDLE -> no resp outputs, state unchanged.

Source files
------------

// File: rtl/cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Round-robin arbiter sharing one physical-memory port between the
//            instruction and data caches, one line transaction at a time.
// Revision : 1.0  initial release
// ============================================================================
module cache_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,

    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic              arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_line_mask = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            r_state;
    logic              r_last_grant_d;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic              r_busy;

    logic              w_icache_req;
    logic              w_dcache_req;
    logic              w_grant_d;
    logic              w_active;

    assign w_icache_req = icache_pmem_read;
    assign w_dcache_req = dcache_pmem_read | dcache_pmem_write;
    // On a tie the data cache wins only if the instruction cache was granted last.
    assign w_grant_d    = w_dcache_req & (~w_icache_req | ~r_last_grant_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_grant_d <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state        <= S_SERVE_D;
                        r_last_grant_d <= 1'b1;
                        r_addr         <= dcache_pmem_address;
                        r_wdata        <= dcache_pmem_wdata;
                        // Read and write together is a writeback.
                        r_pmem_read    <= ~dcache_pmem_write;
                        r_pmem_write   <= dcache_pmem_write;
                        r_busy         <= 1'b1;
                    end else if (w_icache_req) begin
                        r_state        <= S_SERVE_I;
                        r_last_grant_d <= 1'b0;
                        r_addr         <= icache_pmem_address;
                        r_wdata        <= '0;
                        r_pmem_read    <= 1'b1;
                        r_pmem_write   <= 1'b0;
                        r_busy         <= 1'b1;
                    end
                end
                S_SERVE_I, S_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= S_IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even mid-transaction.
    assign w_active          = ~rst;
    assign pmem_read         = r_pmem_read  & w_active;
    assign pmem_write        = r_pmem_write & w_active;
    assign arb_busy          = r_busy       & w_active;
    assign pmem_address      = w_active ? (r_addr & c_line_mask) : '0;
    assign pmem_wdata        = w_active ? r_wdata : '0;

    assign icache_pmem_resp  = w_active & (r_state == S_SERVE_I) & pmem_resp;
    assign dcache_pmem_resp  = w_active & (r_state == S_SERVE_D) & pmem_resp;
    assign icache_pmem_rdata = icache_pmem_resp ? pmem_rdata : '0;
    assign dcache_pmem_rdata = dcache_pmem_resp ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Directed and random checks of cache_arbiter against a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int ADDR_W   = 16;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_address;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              arb_busy;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp),
        .arb_busy            (arb_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the transaction in flight, who owns it, who went last.
    bit                m_busy;
    bit                m_owner_d;
    bit                m_last_d;
    bit                m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    // Observations gathered per directed scenario.
    int                n_pread, n_pwrite, n_iresp, n_dresp;
    logic [ADDR_W-1:0] last_paddr;
    logic [LINE_W-1:0] last_pwdata;
    logic [LINE_W-1:0] last_i_rdata, last_d_rdata;
    logic              obs_busy;
    byte               resp_log[$];

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        n_pread = 0; n_pwrite = 0; n_iresp = 0; n_dresp = 0;
        last_paddr = '0; last_pwdata = '0; last_i_rdata = '0; last_d_rdata = '0;
        resp_log.delete();
    endtask

    // Entered just after a falling edge with inputs already driven; leaves at the next falling edge.
    task automatic tick();
        bit                e_busy, e_iresp, e_dresp;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_wdata;
        #1;
        e_busy  = !rst && m_busy;
        e_iresp = e_busy && !m_owner_d && pmem_resp;
        e_dresp = e_busy &&  m_owner_d && pmem_resp;
        e_addr  = rst ? '0 : m_addr - (m_addr % (2 ** OFFSET_W));
        e_wdata = rst ? '0 : m_wdata;
        chk("arb_busy",     arb_busy,          e_busy);
        chk("pmem_read",    pmem_read,         e_busy && !m_write);
        chk("pmem_write",   pmem_write,        e_busy && m_write);
        chk("pmem_address", pmem_address,      e_addr);
        chk("pmem_wdata",   pmem_wdata,        e_wdata);
        chk("icache_resp",  icache_pmem_resp,  e_iresp);
        chk("dcache_resp",  dcache_pmem_resp,  e_dresp);
        chk("icache_rdata", icache_pmem_rdata, e_iresp ? pmem_rdata : '0);
        chk("dcache_rdata", dcache_pmem_rdata, e_dresp ? pmem_rdata : '0);

        obs_busy = arb_busy;
        if (pmem_read)  n_pread++;
        if (pmem_write) n_pwrite++;
        if (pmem_read || pmem_write) begin
            last_paddr  = pmem_address;
            last_pwdata = pmem_wdata;
        end
        if (icache_pmem_resp) begin n_iresp++; last_i_rdata = icache_pmem_rdata; resp_log.push_back("I"); end
        if (dcache_pmem_resp) begin n_dresp++; last_d_rdata = dcache_pmem_rdata; resp_log.push_back("D"); end

        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_last_d = 0; m_addr = '0; m_wdata = '0; m_write = 0;
        end else if (m_busy) begin
            if (pmem_resp) m_busy = 0;
        end else begin
            bit want_i, want_d, pick_d;
            want_i = icache_pmem_read;
            want_d = dcache_pmem_read || dcache_pmem_write;
            pick_d = (want_i && want_d) ? !m_last_d : want_d;
            if (want_i || want_d) begin
                m_busy    = 1;
                m_owner_d = pick_d;
                m_last_d  = pick_d;
                m_addr    = pick_d ? dcache_pmem_address : icache_pmem_address;
                m_wdata   = pick_d ? dcache_pmem_wdata : '0;
                m_write   = pick_d && dcache_pmem_write;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; pmem_resp = 0; pmem_rdata = '0;
        icache_pmem_read = 0; icache_pmem_address = '0;
        dcache_pmem_read = 0; dcache_pmem_write = 0;
        dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    initial begin
        m_busy = 0; m_owner_d = 0; m_last_d = 0; m_write = 0; m_addr = '0; m_wdata = '0;
        idle_inputs();
        @(negedge clk);

        // Reset state and the cycle after
        clear_obs();
        do_reset();
        tick();
        chk("reset_busy", obs_busy, 1'b0);

        // icache read 0x1234, memory answers on the third strobe cycle
        clear_obs();
        icache_pmem_read = 1; icache_pmem_address = 16'h1234;
        tick();
        tick(); tick();
        pmem_resp = 1; pmem_rdata = {16{8'hA5}};
        tick();
        idle_inputs();
        tick();
        chk("icache_read_cycles", n_pread, 3);
        chk("icache_addr", last_paddr, 16'h1230);
        chk("icache_resp_count", n_iresp, 1);
        chk("icache_rdata_value", last_i_rdata, {16{8'hA5}});

        // Tie from reset: dcache first, then icache on the repeated tie
        clear_obs();
        do_reset();
        icache_pmem_read = 1; icache_pmem_address = 16'h0100;
        dcache_pmem_read = 1; dcache_pmem_address = 16'h0200;
        tick();
        pmem_resp = 1; pmem_rdata = 128'h1111;
        tick();
        pmem_resp = 0;
        tick();
        pmem_resp = 1; pmem_rdata = 128'h2222;
        tick();
        idle_inputs();
        tick();
        chk("tie_resp_count", resp_log.size(), 2);
        if (resp_log.size() == 2) begin
            chk("tie_first_d", resp_log[0], "D");
            chk("tie_second_i", resp_log[1], "I");
        end

        // dcache writeback with inputs changing mid-transaction
        clear_obs();
        dcache_pmem_write = 1; dcache_pmem_address = 16'h4008;
        dcache_pmem_wdata = 128'hDEAD0000_11112222_33334444_0000BEEF;
        tick();
        dcache_pmem_address = 16'h7777; dcache_pmem_wdata = '1;
        tick(); tick();
        pmem_resp = 1;
        tick();
        idle_inputs();
        tick();
        chk("wb_write_cycles", n_pwrite, 3);
        chk("wb_no_read", n_pread, 0);
        chk("wb_addr", last_paddr, 16'h4000);
        chk("wb_wdata", last_pwdata, 128'hDEAD0000_11112222_33334444_0000BEEF);
        chk("wb_resp_count", n_dresp, 1);

        // Read and write together is a write
        clear_obs();
        dcache_pmem_read = 1; dcache_pmem_write = 1; dcache_pmem_address = 16'h2000;
        tick(); tick();
        pmem_resp = 1;
        tick();
        idle_inputs();
        tick();
        chk("rw_write_cycles", n_pwrite, 2);
        chk("rw_no_read", n_pread, 0);

        // Reset in the middle of a dcache read, then a late memory response
        clear_obs();
        dcache_pmem_read = 1; dcache_pmem_address = 16'h3030;
        tick(); tick();
        rst = 1;
        tick();
        idle_inputs();
        pmem_resp = 1; pmem_rdata = 128'h5555;
        tick();
        chk("abort_no_dresp", n_dresp, 0);
        chk("abort_busy", obs_busy, 1'b0);
        tick();
        chk("abort_still_idle", obs_busy, 1'b0);

        // Spurious response in IDLE
        clear_obs();
        pmem_resp = 1; pmem_rdata = 128'h7777;
        tick(); tick();
        chk("spurious_no_resp", n_iresp + n_dresp, 0);
        chk("spurious_busy", obs_busy, 1'b0);
        idle_inputs();
        tick();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst                 = ($urandom_range(0, 39) == 0);
            icache_pmem_read    = $urandom_range(0, 1);
            icache_pmem_address = ADDR_W'($urandom);
            dcache_pmem_read    = $urandom_range(0, 1);
            dcache_pmem_write   = ($urandom_range(0, 2) == 0);
            dcache_pmem_address = ADDR_W'($urandom);
            dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            pmem_rdata          = {$urandom, $urandom, $urandom, $urandom};
            pmem_resp           = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
